// File: rtl/uart_cmd_assembler.sv
// ============================================================================
// uart_cmd_assembler: pairs UART receiver bytes into 16-bit commands
// (high byte first) and drops a half-received command after a timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_cmd_assembler #(
  parameter int TIMEOUT = 52080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        timeout
);

  localparam logic [19:0] TIMER_RELOAD = 20'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_HIGH = 1'b0,
    ST_LOW  = 1'b1
  } state_t;

  state_t      state;
  logic [19:0] timer;
  logic        accept_high;
  logic        accept_low;

  // The byte is acknowledged in the same cycle it is captured, so the
  // receiver drops rdy on the very edge the data is latched.
  assign clr_rx_rdy  = rx_rdy && ((state == ST_HIGH) || (state == ST_LOW));
  assign accept_high = rx_rdy && (state == ST_HIGH);
  assign accept_low  = rx_rdy && (state == ST_LOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_HIGH;
      timer   <= 20'd0;
      cmd     <= 16'h0000;
      cmd_rdy <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        ST_HIGH: begin
          if (accept_high) begin
            cmd[15:8] <= rx_data;
            timeout   <= 1'b0;
            timer     <= TIMER_RELOAD;
            state     <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (accept_low) begin
            cmd[7:0] <= rx_data;
            state    <= ST_HIGH;
          end else if (timer == 20'd0) begin
            // Stale high byte stays on cmd; cmd_rdy was already cleared.
            state   <= ST_HIGH;
            timeout <= 1'b1;
          end else begin
            timer <= timer - 20'd1;
          end
        end
        default: state <= ST_HIGH;
      endcase

      if (accept_low) begin
        cmd_rdy <= 1'b1;
      end else if (accept_high || clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_assembler.sv
// ============================================================================
// tb_uart_cmd_assembler: directed self-checking bench for uart_cmd_assembler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_cmd_assembler;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        timeout;

  int n_cmp;
  int n_bad;

  uart_cmd_assembler #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called 1ns after a rising edge; byte is accepted on the next edge and
  // the task returns 2ns after that accept edge.
  task automatic send_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    #1 check("clr_rx_hi", 16'(clr_rx_rdy), 16'h1);
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    #1 check("clr_rx_lo", 16'(clr_rx_rdy), 16'h0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;

    #3;
    check("rst_cmd", cmd, 16'h0000);
    check("rst_cmd_rdy", 16'(cmd_rdy), 16'h0);
    check("rst_timeout", 16'(timeout), 16'h0);
    check("rst_clr_rx", 16'(clr_rx_rdy), 16'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Basic two-byte command
    send_byte(8'hA5);
    check("hi_a5_cmd_hi", 16'(cmd[15:8]), 16'h00A5);
    check("hi_a5_rdy", 16'(cmd_rdy), 16'h0);
    send_byte(8'h3C);
    check("cmd_a53c", cmd, 16'hA53C);
    check("rdy_a53c", 16'(cmd_rdy), 16'h1);
    check("to_a53c", 16'(timeout), 16'h0);
    tick(3);
    check("rdy_held", 16'(cmd_rdy), 16'h1);

    // Consumer acknowledge
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    check("ack_rdy", 16'(cmd_rdy), 16'h0);
    check("ack_cmd", cmd, 16'hA53C);
    send_byte(8'h12);
    send_byte(8'h34);
    check("cmd_1234", cmd, 16'h1234);
    check("rdy_1234", 16'(cmd_rdy), 16'h1);

    // Timeout after exactly 16 idle cycles
    tick(1);
    send_byte(8'hFF);
    check("ff_rdy_clr", 16'(cmd_rdy), 16'h0);
    tick(15);
    check("to_edge_minus1", 16'(timeout), 16'h0);
    tick(1);
    check("to_edge", 16'(timeout), 16'h1);
    check("to_stale_cmd", cmd, 16'hFF34);
    check("to_rdy", 16'(cmd_rdy), 16'h0);
    tick(2);
    send_byte(8'h01);
    check("to_cleared", 16'(timeout), 16'h0);
    send_byte(8'h02);
    check("cmd_0102", cmd, 16'h0102);
    check("rdy_0102", 16'(cmd_rdy), 16'h1);

    // Low byte arriving in the timer==0 cycle is accepted
    tick(1);
    send_byte(8'h55);
    tick(15);
    send_byte(8'hAA);
    check("cmd_55aa", cmd, 16'h55AA);
    check("rdy_55aa", 16'(cmd_rdy), 16'h1);
    check("to_55aa", 16'(timeout), 16'h0);

    // One cycle later it is too late and starts a new command
    tick(1);
    send_byte(8'h66);
    tick(16);
    check("late_to", 16'(timeout), 16'h1);
    check("late_rdy", 16'(cmd_rdy), 16'h0);
    send_byte(8'h99);
    check("late_new_hi", 16'(cmd[15:8]), 16'h0099);
    check("late_to_clr", 16'(timeout), 16'h0);
    send_byte(8'h88);
    check("cmd_9988", cmd, 16'h9988);
    check("rdy_9988", 16'(cmd_rdy), 16'h1);

    // Set wins over clr_cmd_rdy in the low-byte cycle
    tick(1);
    send_byte(8'h11);
    clr_cmd_rdy = 1'b1;
    send_byte(8'h22);
    check("setwin_rdy", 16'(cmd_rdy), 16'h1);
    check("setwin_cmd", cmd, 16'h1122);
    clr_cmd_rdy = 1'b0;
    tick(2);
    check("setwin_hold", 16'(cmd_rdy), 16'h1);

    // Back-to-back bytes, one per cycle
    rx_rdy  = 1'b1;
    rx_data = 8'hC1;
    tick(1);
    rx_data = 8'hC2;
    #1 check("b2b_clr_rx", 16'(clr_rx_rdy), 16'h1);
    tick(1);
    rx_rdy = 1'b0;
    check("cmd_c1c2", cmd, 16'hC1C2);
    check("rdy_c1c2", 16'(cmd_rdy), 16'h1);

    // Asynchronous reset in the middle of a command
    tick(1);
    send_byte(8'h77);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cmd", cmd, 16'h0000);
    check("mid_rst_rdy", 16'(cmd_rdy), 16'h0);
    check("mid_rst_to", 16'(timeout), 16'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    send_byte(8'hAB);
    send_byte(8'hCD);
    check("cmd_abcd", cmd, 16'hABCD);
    check("rdy_abcd", 16'(cmd_rdy), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
